// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for alu_seq
//
// Groups the operand channel (in_valid/in_ready/opcode/a/b), the result
// channel (out_valid/out_ready/x/y/flags) and the busy status.
//   slave  : the ALU side (drives in_ready, out_valid, x, y, flags, busy)
//   master : the operand source / result consumer side
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [3:0]       flags;
  logic             busy;

  modport slave (
    input  in_valid, opcode, a, b, out_ready,
    output in_ready, out_valid, x, y, flags, busy
  );

  modport master (
    output in_valid, opcode, a, b, out_ready,
    input  in_ready, out_valid, x, y, flags, busy
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - WIDTH-bit ALU with registered, handshaked result and iterative multiply
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : alu_seq_if.slave
//          in_valid/in_ready/opcode/a/b   operation request
//          out_valid/out_ready/x/y/flags  result slot, flags = {z,n,c,v}
//          busy                           multiply in progress
// Non-multiply ops complete in one cycle; multiply is shift-add, one bit of b
// per cycle, WIDTH cycles total.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] OP_MUL = 4'b1100;

  typedef enum logic {IDLE, MUL} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [CW-1:0]      cnt;
  logic               mul_last;

  logic               out_valid_q;
  logic [WIDTH-1:0]   x_q, y_q;
  logic [3:0]         flags_q;

  logic               in_ready_c, busy_c, accept, accept_mul;

  logic [WIDTH-1:0]   rx, ry;
  logic               rc, rv;

  // Single-cycle result for every opcode except multiply.
  always_comb begin
    rx = '0;
    ry = '0;
    rc = 1'b0;
    rv = 1'b0;
    case (bus.opcode)
      4'b0000: rx[0] = |bus.a;
      4'b0001: rx[0] = &bus.a;
      4'b0010: rx[0] = ^bus.a;
      4'b0011: rx = bus.a & bus.b;
      4'b0100: rx = bus.a | bus.b;
      4'b0101: rx = bus.a ^ bus.b;
      4'b0110: rx[0] = bus.a > bus.b;
      4'b0111: rx[0] = bus.a < bus.b;
      4'b1000: rx[0] = (bus.a == '0);
      4'b1001: rx[0] = (bus.a == bus.b);
      4'b1010: begin
        {ry[0], rx} = {1'b0, bus.a} + {1'b0, bus.b};
        rc = ry[0];
        // Overflow when both operands share a sign the sum does not.
        rv = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (rx[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b1011: begin
        rx = bus.a - bus.b;
        rc = bus.a < bus.b;
        // Overflow when operand signs differ and the result sign differs from a.
        rv = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (rx[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b1101: rx = bus.a >> bus.b;
      4'b1110: {ry, rx} = {{WIDTH{1'b0}}, bus.a} << bus.b;
      4'b1111: rx = ~bus.a;
      default: ; // multiply is produced by the MUL state
    endcase
  end

  // Partial product for the current bit; on the last step this is the product.
  always_comb begin
    acc_next = acc;
    if (b_reg[cnt]) begin
      acc_next = acc + ({{WIDTH{1'b0}}, a_reg} << cnt);
    end
  end

  assign mul_last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready_c = 1'b0;
    busy_c     = 1'b0;
    accept     = 1'b0;
    accept_mul = 1'b0;
    case (state)
      IDLE: begin
        // The slot can take a new result if it is empty or being drained now.
        in_ready_c = !out_valid_q || bus.out_ready;
        accept     = bus.in_valid && in_ready_c;
        accept_mul = accept && (bus.opcode == OP_MUL);
        if (accept_mul) begin
          next_state = MUL;
        end
      end
      MUL: begin
        busy_c = 1'b1;
        if (mul_last) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      flags_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_mul) begin
            a_reg       <= bus.a;
            b_reg       <= bus.b;
            acc         <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
          end else if (accept) begin
            x_q         <= rx;
            y_q         <= ry;
            flags_q     <= {(rx == '0), rx[WIDTH-1], rc, rv};
            out_valid_q <= 1'b1;
          end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        MUL: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (mul_last) begin
            x_q         <= acc_next[WIDTH-1:0];
            y_q         <= acc_next[2*WIDTH-1:WIDTH];
            flags_q     <= {(acc_next[WIDTH-1:0] == '0), acc_next[WIDTH-1], 2'b00};
            out_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH=8)
module tb_alu_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {flags[3:0], y[7:0], x[7:0]}.
  function automatic logic [19:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, r, sa, sb, sr;
    logic [7:0] x, y;
    logic c, v;
    ia = int'(a);
    ib = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    x = 8'd0; y = 8'd0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0:  x = {7'd0, ia != 0};
      4'd1:  x = {7'd0, ia == 255};
      4'd2:  x = {7'd0, ($countones(a) % 2) == 1};
      4'd3:  x = a & b;
      4'd4:  x = a | b;
      4'd5:  x = a ^ b;
      4'd6:  x = {7'd0, ia > ib};
      4'd7:  x = {7'd0, ia < ib};
      4'd8:  x = {7'd0, ia == 0};
      4'd9:  x = {7'd0, ia == ib};
      4'd10: begin
        r = ia + ib; x = 8'(r % 256); y = 8'(r / 256); c = r > 255;
        sr = sa + sb; v = (sr > 127) || (sr < -128);
      end
      4'd11: begin
        r = ia - ib; x = 8'((r + 256) % 256); c = ia < ib;
        sr = sa - sb; v = (sr > 127) || (sr < -128);
      end
      4'd12: begin
        r = ia * ib; x = 8'(r % 256); y = 8'(r / 256);
      end
      4'd13: x = (ib >= 8) ? 8'd0 : 8'(ia / (1 << ib));
      4'd14: begin
        r = (ib >= 16) ? 0 : (ia * (1 << ib)) % 65536;
        x = 8'(r % 256); y = 8'(r / 256);
      end
      default: x = 8'(255 - ia);
    endcase
    return {(x == 8'd0), x[7], c, v, y, x};
  endfunction

  // Present an operation and hold it until the accepting edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.a        = a;
    bus.b        = b;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Wait for out_valid (out_ready held high) and return {flags,y,x}.
  task automatic recv(output logic [19:0] r, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 50);
    if (!bus.out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL recv_timeout: out_valid=%0b required 1", bus.out_valid);
    end
    r = {bus.flags, bus.y, bus.x};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.opcode = 4'd0; bus.a = 8'd0; bus.b = 8'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.busy, bus.in_ready, bus.flags, bus.y, bus.x} !== {1'b0, 1'b0, 1'b1, 20'd0}) begin
      n_fail++;
      $display("FAIL reset_state: ov/busy/ir/f/y/x=%b required %b",
               {bus.out_valid, bus.busy, bus.in_ready, bus.flags, bus.y, bus.x}, {3'b001, 20'd0});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [19:0] r;
    int lat;
    logic [3:0]  ops [8] = '{4'hA, 4'hA, 4'hB, 4'h9, 4'hE, 4'hD, 4'hE, 4'hD};
    logic [7:0]  aa  [8] = '{8'hFF, 8'h7F, 8'h00, 8'h5A, 8'h81, 8'hFF, 8'h01, 8'h80};
    logic [7:0]  bb  [8] = '{8'h01, 8'h01, 8'h01, 8'h5A, 8'h01, 8'h09, 8'h10, 8'h07};
    logic [19:0] ex  [8] = '{{4'b1010, 8'h01, 8'h00}, {4'b0101, 8'h00, 8'h80},
                             {4'b0110, 8'h00, 8'hFF}, {4'b0000, 8'h00, 8'h01},
                             {4'b0000, 8'h01, 8'h02}, {4'b1000, 8'h00, 8'h00},
                             {4'b1000, 8'h00, 8'h00}, {4'b0000, 8'h00, 8'h01}};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(ops[i], aa[i], bb[i]);
      recv(r, lat);
      n_checks++;
      if (r !== ex[i] || lat != 1) begin
        n_fail++;
        $display("FAIL directed_%0d op=%h a=%h b=%h: got f/y/x=%h lat=%0d required %h lat=1",
                 i, ops[i], aa[i], bb[i], r, lat, ex[i]);
      end
    end
  endtask

  task automatic test_mul;
    logic ok;
    bus.out_ready = 1'b1;
    send(4'hC, 8'hFF, 8'hFF);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!(bus.busy === 1'b1 && bus.in_ready === 1'b0 && bus.out_valid === 1'b0)) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mul_busy: busy/in_ready/out_valid=%b%b%b required 100 for 8 cycles",
               bus.busy, bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.busy, bus.flags, bus.y, bus.x} !== {2'b10, 4'b0000, 8'hFE, 8'h01}) begin
      n_fail++;
      $display("FAIL mul_result: ov/busy/f/y/x=%b/%b/%h/%h/%h required 1/0/0/fe/01",
               bus.out_valid, bus.busy, bus.flags, bus.y, bus.x);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] oo [3] = '{4'h3, 4'h4, 4'h5};
    logic [7:0] aa [3];
    logic [7:0] bb [3];
    logic [19:0] e;
    for (int i = 0; i < 3; i++) begin
      aa[i] = 8'($urandom);
      bb[i] = 8'($urandom);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.opcode = oo[0]; bus.a = aa[0]; bus.b = bb[0];
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      e = model(oo[i-1], aa[i-1], bb[i-1]);
      n_checks++;
      if ({bus.out_valid, bus.in_ready, bus.flags, bus.y, bus.x} !== {2'b11, e}) begin
        n_fail++;
        $display("FAIL b2b_%0d: ov/ir/fyx=%b%b/%h required 11/%h", i,
                 bus.out_valid, bus.in_ready, {bus.flags, bus.y, bus.x}, e);
      end
      if (i < 3) begin
        bus.opcode = oo[i]; bus.a = aa[i]; bus.b = bb[i];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [19:0] e0, e1;
    e0 = model(4'hA, 8'h10, 8'h20);
    e1 = model(4'h5, 8'h3C, 8'hA5);
    bus.out_ready = 1'b0;
    send(4'hA, 8'h10, 8'h20);
    bus.in_valid = 1'b1; bus.opcode = 4'h5; bus.a = 8'h3C; bus.b = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.in_ready, bus.flags, bus.y, bus.x} !== {2'b10, e0}) begin
        n_fail++;
        $display("FAIL stall_%0d: ov/ir/fyx=%b%b/%h required 10/%h", i,
                 bus.out_valid, bus.in_ready, {bus.flags, bus.y, bus.x}, e0);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.flags, bus.y, bus.x} !== {1'b1, e1}) begin
      n_fail++;
      $display("FAIL stall_next: ov/fyx=%b/%h required 1/%h", bus.out_valid,
               {bus.flags, bus.y, bus.x}, e1);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.flags, bus.y, bus.x} !== {1'b0, e1}) begin
      n_fail++;
      $display("FAIL stall_hold: ov/fyx=%b/%h required 0/%h (values kept)", bus.out_valid,
               {bus.flags, bus.y, bus.x}, e1);
    end
  endtask

  task automatic test_reset_mid_mul;
    logic seen;
    bus.out_ready = 1'b1;
    send(4'hC, 8'h37, 8'hC9);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.busy, bus.x, bus.y} !== 18'd0) begin
      n_fail++;
      $display("FAIL rst_mul_abort: ov/busy/x/y=%b%b/%h/%h required 00/00/00",
               bus.out_valid, bus.busy, bus.x, bus.y);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mul_noresult: spurious=%b in_ready=%b required 0/1", seen, bus.in_ready);
    end
  endtask

  task automatic test_random;
    logic [3:0]  op;
    logic [7:0]  a, b;
    logic [19:0] r, e;
    int lat, el;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      b  = (op == 4'hD || op == 4'hE) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      send(op, a, b);
      recv(r, lat);
      e  = model(op, a, b);
      el = (op == 4'hC) ? 9 : 1;
      n_checks++;
      if (r !== e || lat != el) begin
        n_fail++;
        $display("FAIL random_%0d op=%h a=%h b=%h: got f/y/x=%h lat=%0d required %h lat=%0d",
                 i, op, a, b, r, lat, e, el);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    test_directed;
    test_mul;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_mul;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
